regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-issue register file.
- Supports NRD combinational read ports and two write ports (WB0 = main pipe, WB1 = second/long-latency pipe).
- Write-to-read bypass on every read port.
- Per-register pending-write scoreboard, so decode can stall on operands still in flight.
- Sits between decode (read, issue) and the writeback stages.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers.
- NRD, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- raddr  in  NRD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rdata  out  NRD*DATA_W  read data, combinational.
- rbusy  out  NRD  operand of port i is pending and not bypassed this cycle.
- we0  in  1  write enable, port 0 (WB0).
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (WB1, younger/priority).
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- issue  in  1  an instruction with destination issue_addr is leaving decode.
- issue_addr  in  ADDR_W  destination register of the issuing instruction.
- flush  in  1  clear the whole scoreboard (pipeline flush).
- busy_vec  out  NREG  scoreboard state, registered.

Behaviour:
- Reset (resetn=0, asynchronous):
  - All registers are 0 and busy_vec is 0.
  - rdata is forced to 0 and rbusy to 0 while reset is asserted, regardless of inputs.
- Register 0 is hardwired to 0:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0 with rbusy=0.
  - An issue to address 0 is ignored.
- Writes occur on the clock edge and are visible in the array from the next cycle.
- If we0 and we1 target the same nonzero address in one cycle, port 1 wins and wdata0 is dropped.
- Read port i, priority order:
  - raddr==0 -> 0;
  - otherwise we1 && waddr1==raddr -> wdata1;
  - otherwise we0 && waddr0==raddr -> wdata0;
  - otherwise the array value.
  - Read is zero-latency combinational.
- Scoreboard next state for register r, evaluated per register with priority:
  - flush -> 0;
  - otherwise issue && issue_addr==r -> 1;
  - otherwise a write to r on either port -> 0;
  - otherwise hold.
  - Issue and write to the same r in one cycle leaves busy=1, because the issuing instruction is newer.
- rbusy[i] = busy_vec[raddr_i] && !(write to raddr_i on either port this cycle) && raddr_i!=0.
- Flush also wins over a same-cycle issue; the issuing instruction is treated as flushed.
- Issue to an already-busy register keeps it busy; the single bit does not count outstanding writes.
- The scoreboard is never modified by reads.

Optional Feature:
- REGFILE_SB_CHK_EN defined: adds output sb_err (1 bit, registered, sticky until reset). It sets on either of:
  - an issue to a nonzero register already busy and not written in that cycle;
  - we0 && we1 to the same nonzero address.
- Not defined: no sb_err port and no checking logic; behaviour is otherwise identical.

Decomposition:
- Shared defines file: RstEnable (1'b0), WriteEnable (1'b1), ZeroWord, default DATA_W/ADDR_W.
- One natural sub-module: regfile_rd_bypass, instantiated NRD times via generate. It is a single read port (zero check, two-level bypass mux, rbusy term).

Test Plan:
- Reset: write r5=0x1234 via we0, pulse resetn low mid-cycle -> rdata immediately 0; after release, read r5 -> 0 and busy_vec=0.
- Bypass priority: we0 r3=0xAAAA and we1 r3=0x5555 in the same cycle, raddr r3 -> rdata=0x5555 that cycle; the next cycle the array read also gives 0x5555.
- r0 protection: we1 r0=0xFFFFFFFF plus issue r0 -> read r0 gives 0, rbusy=0, busy_vec[0]=0.
- Scoreboard lifecycle:
  - issue r7 -> busy_vec[7]=1 next cycle and rbusy=1 for raddr r7.
  - we0 r7=0x77 -> rbusy=0 and rdata=0x77 the same cycle; busy_vec[7]=0 next cycle.
- Simultaneous events:
  - issue r9 while we1 writes r9 -> busy_vec[9] stays 1.
  - flush with issue r9 -> busy_vec all 0.
- With REGFILE_SB_CHK_EN: issue r4 twice without a write -> sb_err=1 one cycle after the second issue, holds until resetn=0.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants for the multi-port register file with pending-write scoreboard.
// Build option: REGFILE_SB_CHK_EN adds the sticky scoreboard-misuse flag sb_err.
package regfile_mp_sb_pkg;

    localparam logic        RstEnable   = 1'b0;
    localparam logic        WriteEnable = 1'b1;
    localparam int          DEF_DATA_W  = 32;
    localparam int          DEF_ADDR_W  = 5;
    localparam logic [DEF_DATA_W-1:0] ZeroWord = '0;

endpackage

// File: rtl/regfile_mp_sb_rd_bypass.sv
// One combinational read port: r0 check, WB1-over-WB0 bypass, and the stall term.
module regfile_rd_bypass
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
)(
    input  logic              i_resetn,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [DATA_W-1:0] i_arrData,
    input  logic              i_busy,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_waddr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_waddr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rbusy
);

    logic w_hit0;
    logic w_hit1;

    assign w_hit0 = (i_we0 == WriteEnable) && (i_waddr0 == i_raddr);
    assign w_hit1 = (i_we1 == WriteEnable) && (i_waddr1 == i_raddr);

    // WB1 is the younger writer, so its data shadows WB0 when both hit
    always_comb begin
        o_rdata = {DATA_W{ZeroWord[0]}};
        o_rbusy = 1'b0;
        if (i_resetn != RstEnable && i_raddr != '0) begin
            if (w_hit1) begin
                o_rdata = i_wdata1;
            end else if (w_hit0) begin
                o_rdata = i_wdata0;
            end else begin
                o_rdata = i_arrData;
            end
            o_rbusy = i_busy && !(w_hit0 || w_hit1);
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Register file with NRD bypassed read ports, two writeback ports and a pending-write scoreboard.
// Build option: REGFILE_SB_CHK_EN adds output sb_err (sticky scoreboard-misuse flag).
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = 2
)(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NRD*ADDR_W-1:0]   raddr,
    output logic [NRD*DATA_W-1:0]   rdata,
    output logic [NRD-1:0]          rbusy,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       waddr0,
    input  logic [DATA_W-1:0]       wdata0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       waddr1,
    input  logic [DATA_W-1:0]       wdata1,
    input  logic                    issue,
    input  logic [ADDR_W-1:0]       issue_addr,
    input  logic                    flush,
    output logic [(2**ADDR_W)-1:0]  busy_vec
`ifdef REGFILE_SB_CHK_EN
    ,
    output logic                    sb_err
`endif
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [NREG];
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_busyNext;
    logic [NREG-1:0]   w_wrHit;
    logic              w_we0;
    logic              w_we1;

    assign w_we0 = (we0 == WriteEnable);
    assign w_we1 = (we1 == WriteEnable);

    // Per-register "written by either port this cycle"; r0 never counts as written
    always_comb begin
        w_wrHit = '0;
        for (int r = 1; r < NREG; r++) begin
            w_wrHit[r] = (w_we0 && waddr0 == ADDR_W'(r)) || (w_we1 && waddr1 == ADDR_W'(r));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (resetn == RstEnable) begin
            for (int r = 0; r < NREG; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w_we1 && waddr1 == ADDR_W'(r)) begin
                    r_mem[r] <= wdata1;
                end else if (w_we0 && waddr0 == ADDR_W'(r)) begin
                    r_mem[r] <= wdata0;
                end
            end
        end
    end

    // An issue is newer than any write landing the same cycle, so it keeps the bit set
    always_comb begin
        w_busyNext = r_busy;
        for (int r = 0; r < NREG; r++) begin
            if (flush) begin
                w_busyNext[r] = 1'b0;
            end else if (issue && r != 0 && issue_addr == ADDR_W'(r)) begin
                w_busyNext[r] = 1'b1;
            end else if (w_wrHit[r]) begin
                w_busyNext[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (resetn == RstEnable) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    assign busy_vec = r_busy;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = raddr[g*ADDR_W +: ADDR_W];

        regfile_rd_bypass #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .i_resetn  (resetn),
            .i_raddr   (w_addr),
            .i_arrData (r_mem[w_addr]),
            .i_busy    (r_busy[w_addr]),
            .i_we0     (we0),
            .i_waddr0  (waddr0),
            .i_wdata0  (wdata0),
            .i_we1     (we1),
            .i_waddr1  (waddr1),
            .i_wdata1  (wdata1),
            .o_rdata   (rdata[g*DATA_W +: DATA_W]),
            .o_rbusy   (rbusy[g])
        );
    end

`ifdef REGFILE_SB_CHK_EN
    logic w_errSet;
    logic r_err;

    // Double issue without an intervening write, or two writebacks colliding on one register
    assign w_errSet = (issue && issue_addr != '0 && r_busy[issue_addr] && !w_wrHit[issue_addr])
                    || (w_we0 && w_we1 && waddr0 == waddr1 && waddr0 != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (resetn == RstEnable) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_errSet;
        end
    end

    assign sb_err = r_err;
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: reset, bypass priority, r0 protection, scoreboard lifecycle.
module tb_regfile_mp_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;

    logic                  clk;
    logic                  resetn;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rbusy;
    logic                  we0;
    logic [ADDR_W-1:0]     waddr0;
    logic [DATA_W-1:0]     wdata0;
    logic                  we1;
    logic [ADDR_W-1:0]     waddr1;
    logic [DATA_W-1:0]     wdata1;
    logic                  issue;
    logic [ADDR_W-1:0]     issue_addr;
    logic                  flush;
    logic [31:0]           busy_vec;
`ifdef REGFILE_SB_CHK_EN
    logic                  sb_err;
`endif

    int total = 0;
    int bad   = 0;

    regfile_mp_sb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NRD    (NRD)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .we0        (we0),
        .waddr0     (waddr0),
        .wdata0     (wdata0),
        .we1        (we1),
        .waddr1     (waddr1),
        .wdata1     (wdata1),
        .issue      (issue),
        .issue_addr (issue_addr),
        .flush      (flush),
        .busy_vec   (busy_vec)
`ifdef REGFILE_SB_CHK_EN
        ,
        .sb_err     (sb_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic iWe0, input logic [4:0] iA0, input logic [31:0] iD0,
                                 input logic iWe1, input logic [4:0] iA1, input logic [31:0] iD1,
                                 input logic iIssue, input logic [4:0] iIa, input logic iFlush,
                                 input logic [4:0] iR0, input logic [4:0] iR1);
        we0 = iWe0;  waddr0 = iA0; wdata0 = iD0;
        we1 = iWe1;  waddr1 = iA1; wdata1 = iD1;
        issue = iIssue; issue_addr = iIa; flush = iFlush;
        raddr = {iR1, iR0};
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
        checkOutput("rst_rdata", rdata, 64'h0);
        checkOutput("rst_busy", busy_vec, 0);
        #10 resetn = 1'b1;
        step();

        // write r5, read back from the array, then assert reset mid-cycle
        applyStimulus(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 5, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 0, 5, 0);
        checkOutput("r5_array", rdata[31:0], 32'h1234);
        #1 resetn = 1'b0;
        #1;
        checkOutput("rst_async_rdata", rdata[31:0], 0);
        checkOutput("rst_async_rbusy", rbusy, 0);
        resetn = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        checkOutput("r5_after_rst", rdata[31:0], 0);
        checkOutput("busy_after_rst", busy_vec, 0);
        step();

        // same-cycle WB0/WB1 collision on r3: WB1 wins in bypass and in the array
        applyStimulus(1, 3, 32'hAAAA, 1, 3, 32'h5555, 0, 0, 0, 3, 3);
        checkOutput("byp_wb1_p0", rdata[31:0], 32'h5555);
        checkOutput("byp_wb1_p1", rdata[63:32], 32'h5555);
        step();
        applyStimulus(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 3, 6);
        checkOutput("arr_r3", rdata[31:0], 32'h5555);
        checkOutput("byp_wb0_p1", rdata[63:32], 32'h66);
        step();

        // r0 is immune to writes and issues
        applyStimulus(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 6);
        checkOutput("r0_byp", rdata[31:0], 0);
        checkOutput("r0_rbusy", rbusy[0], 0);
        checkOutput("r6_array", rdata[63:32], 32'h66);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r0_busyvec", busy_vec, 0);
        checkOutput("r0_array", rdata[31:0], 0);

        // scoreboard lifecycle on r7
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0);
        checkOutput("r7_pre_busy", rbusy[0], 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        checkOutput("r7_busyvec", busy_vec, 32'h80);
        checkOutput("r7_rbusy", rbusy[0], 1);
        applyStimulus(1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 7, 7);
        checkOutput("r7_wr_rbusy", rbusy, 2'b00);
        checkOutput("r7_wr_rdata", rdata[31:0], 32'h77);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        checkOutput("r7_cleared", busy_vec, 0);
        checkOutput("r7_array", rdata[31:0], 32'h77);

        // issue and write to r9 in the same cycle leaves it busy
        applyStimulus(0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 0, 9);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        checkOutput("r9_busyvec", busy_vec, 32'h200);
        checkOutput("r9_rbusy", rbusy, 2'b10);
        checkOutput("r9_data", rdata[63:32], 32'h99);

        // multiple outstanding, partial retire, then flush beats issue
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 1, 9, 32'h1, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 9);
        checkOutput("multi_busy", busy_vec, 32'h4);
        checkOutput("multi_rbusy", rbusy, 2'b01);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 9);
        checkOutput("flush_busy", busy_vec, 0);
        checkOutput("flush_rbusy", rbusy, 2'b00);

`ifdef REGFILE_SB_CHK_EN
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        step();
        checkOutput("err_first_issue", sb_err, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        checkOutput("err_before_edge", sb_err, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("err_set", sb_err, 1);
        step();
        step();
        checkOutput("err_sticky", sb_err, 1);
        resetn = 1'b0;
        #1;
        checkOutput("err_rst", sb_err, 0);
        resetn = 1'b1;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
